// File: rtl/memory_cc.sv
// memory_cc: memory stage of the five-stage RISC-V pipeline.
// Word-addressed data memory with async read and synchronous store, plus
// the M/W pipeline register and the combinational writeback mux ResultW.
// Optional feature macro: MEMORY_CC_BOUNDS_CHECK_EN (alignment/range fault
// checking with a sticky MemFaultW flag). Undefined: addresses are truncated
// to the word index and MemFaultW is tied to 0.
module memory_cc #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RDW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic        MemFaultW
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   readData;
  logic          storeEn;

  assign idx = ALUResultM[AW+1:2];

  // NOTE: every always_comb below assigns each of its outputs a default
  // first; a path that leaves one unassigned would infer a latch.
`ifdef MEMORY_CC_BOUNDS_CHECK_EN
  logic isAccess;
  logic badAddr;
  logic fault;

  // Classify the access; a faulting access neither stores nor returns data
  always_comb begin
    storeEn  = MemWriteM;
    readData = mem[idx];
    isAccess = MemWriteM || (ResultSrcM && RegWriteM);
    badAddr  = (ALUResultM[1:0] != 2'b00) || (ALUResultM[31:AW+2] != '0);
    fault    = isAccess && badAddr;
    if (fault) begin
      storeEn  = 1'b0;
      readData = '0;
    end
  end

  // Sticky fault flag, set at the faulting edge and cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       MemFaultW <= 1'b0;
    else if (fault) MemFaultW <= 1'b1;
  end
`else
  // Unchecked access: the address is simply truncated to the word index
  always_comb begin
    storeEn  = MemWriteM;
    readData = mem[idx];
  end

  assign MemFaultW = 1'b0;
`endif

  // Data memory: full-word store on the clock edge, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the memory is reset word by word, so it maps to flops rather
      // than a RAM macro; keep DEPTH small when this stage is reused.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (storeEn) begin
      mem[idx] <= WriteDataM;
    end
  end

  // M/W pipeline register; ReadDataW takes the pre-store read value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state is written with <= so every register samples the values
      // from before the edge, which is also what gives read-before-write.
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RDW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RDW        <= RDM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= readData;
    end
  end

  // Writeback mux; depends on W-side registers only
  assign ResultW = ResultSrcW ? ReadDataW : ALUResultW;

endmodule

// File: tb/tb_memory_cc.sv
// tb_memory_cc: directed test of memory_cc against a word-array model.
// Follows MEMORY_CC_BOUNDS_CHECK_EN the same way the design does.
module tb_memory_cc;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        ResultSrcM;
  logic        MemWriteM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RDW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] ResultW;
  logic        MemFaultW;

  int total = 0;
  int bad   = 0;

  memory_cc #(.DEPTH(64), .AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .RDM        (RDM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RDW        (RDW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .ResultW    (ResultW),
    .MemFaultW  (MemFaultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned wordOf(input logic [31:0] a);
    return (a / 4) % 64;
  endfunction

  function automatic bit faults(input logic mw, input logic src, input logic rw,
                                input logic [31:0] a);
`ifdef MEMORY_CC_BOUNDS_CHECK_EN
    return (mw || (src && rw)) && ((a % 4) != 0 || a >= 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] mMem [64];
  logic        eRegWrite;
  logic        eSrc;
  logic [4:0]  eRd;
  logic [31:0] eAlu;
  logic [31:0] eRead;
  logic        eFault;

  // Model of the stage: what W must hold after each edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mMem[i] <= '0;
      eRegWrite <= 1'b0;
      eSrc      <= 1'b0;
      eRd       <= '0;
      eAlu      <= '0;
      eRead     <= '0;
      eFault    <= 1'b0;
    end else begin
      eRegWrite <= RegWriteM;
      eSrc      <= ResultSrcM;
      eRd       <= RDM;
      eAlu      <= ALUResultM;
      if (faults(MemWriteM, ResultSrcM, RegWriteM, ALUResultM)) begin
        eRead  <= '0;
        eFault <= 1'b1;
      end else begin
        eRead <= mMem[wordOf(ALUResultM)];
        if (MemWriteM) mMem[wordOf(ALUResultM)] <= WriteDataM;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    check("RegWriteW",  {31'b0, RegWriteW},  {31'b0, eRegWrite});
    check("ResultSrcW", {31'b0, ResultSrcW}, {31'b0, eSrc});
    check("RDW",        {27'b0, RDW},        {27'b0, eRd});
    check("ALUResultW", ALUResultW,          eAlu);
    check("ReadDataW",  ReadDataW,           eRead);
    check("ResultW",    ResultW,             eSrc ? eRead : eAlu);
    check("MemFaultW",  {31'b0, MemFaultW},  {31'b0, eFault});
  end

  // ---------------- directed stimulus ----------------
  // Present one M-side vector, let one edge capture it, return 1 ns after.
  task automatic drive(input logic rw, input logic src, input logic mw,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd);
    RegWriteM  = rw;
    ResultSrcM = src;
    MemWriteM  = mw;
    RDM        = rd;
    ALUResultM = alu;
    WriteDataM = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] a);
    drive(1'b1, 1'b1, 1'b0, rd, a, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, 5'd0, a, d);
  endtask

  task automatic bubble();
    RegWriteM  = 1'b0;
    ResultSrcM = 1'b0;
    MemWriteM  = 1'b0;
    RDM        = '0;
    ALUResultM = '0;
    WriteDataM = '0;
  endtask

  initial begin
    // Reset held with a store pending: nothing may change
    rst        = 1'b0;
    RegWriteM  = 1'b1;
    ResultSrcM = 1'b1;
    MemWriteM  = 1'b1;
    RDM        = 5'd9;
    ALUResultM = 32'h0;
    WriteDataM = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst RegWriteW", {31'b0, RegWriteW}, 32'h0);
    check("rst RDW",       {27'b0, RDW},       32'h0);
    check("rst ReadDataW", ReadDataW,          32'h0);
    check("rst ResultW",   ResultW,            32'h0);
    check("rst MemFaultW", {31'b0, MemFaultW}, 32'h0);
    bubble();
    @(negedge clk);
    rst = 1'b1;

    load(5'd3, 32'h0);
    check("load0 after rst", ReadDataW, 32'h0);

    // Store then load
    store(32'd8, 32'h0000001E);
    load(5'd5, 32'd8);
    check("st/ld ReadDataW", ReadDataW, 32'h1E);
    check("st/ld ResultW",   ResultW,   32'h1E);
    check("st/ld RDW",       {27'b0, RDW}, 32'd5);
    check("st/ld RegWriteW", {31'b0, RegWriteW}, 32'd1);

    // ALU passthrough, with store data present but no store enable
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'd30, 32'h0BAD);
    check("alu ALUResultW", ALUResultW, 32'd30);
    check("alu ResultW",    ResultW,    32'd30);
    check("alu RDW",        {27'b0, RDW}, 32'd7);
    load(5'd1, 32'd28);
    check("alu no write", ReadDataW, 32'h0);

    // Read-before-write on the same index
    store(32'd8, 32'h11);
    drive(1'b1, 1'b1, 1'b1, 5'd2, 32'd8, 32'h22);
    check("rbw old value", ReadDataW, 32'h11);
    load(5'd2, 32'd8);
    check("rbw new value", ReadDataW, 32'h22);

    // Back-to-back stores: last wins
    store(32'd12, 32'h10);
    store(32'd12, 32'h20);
    load(5'd4, 32'd12);
    check("b2b last wins", ResultW, 32'h20);

    // Async reset between edges with a store pending
    store(32'd0, 32'hA);
    store(32'd4, 32'hB);
    load(5'd6, 32'd4);
    check("pre-rst load", ResultW, 32'hB);
    RegWriteM  = 1'b0;
    ResultSrcM = 1'b0;
    MemWriteM  = 1'b1;
    ALUResultM = 32'd8;
    WriteDataM = 32'h77;
    #1 rst = 1'b0;
    #1;
    check("async ResultW",   ResultW,            32'h0);
    check("async RDW",       {27'b0, RDW},       32'h0);
    check("async RegWriteW", {31'b0, RegWriteW}, 32'h0);
    check("async ResultSrc", {31'b0, ResultSrcW}, 32'h0);
    #1 rst = 1'b1;
    load(5'd1, 32'd0);
    check("post-rst mem0", ResultW, 32'h0);
    load(5'd1, 32'd4);
    check("post-rst mem1", ResultW, 32'h0);
    load(5'd1, 32'd8);
    check("post-rst mem2", ResultW, 32'h0);

    // Misaligned and out-of-range stores
    store(32'h102, 32'h55);
`ifdef MEMORY_CC_BOUNDS_CHECK_EN
    check("misalign fault", {31'b0, MemFaultW}, 32'd1);
`else
    check("misalign nofault", {31'b0, MemFaultW}, 32'd0);
`endif
    load(5'd8, 32'h0);
`ifdef MEMORY_CC_BOUNDS_CHECK_EN
    check("misalign no write", ReadDataW, 32'h0);
`else
    check("misalign truncated", ReadDataW, 32'h55);
`endif
    store(32'h100, 32'h66);
    load(5'd8, 32'h0);
`ifdef MEMORY_CC_BOUNDS_CHECK_EN
    check("range no write", ReadDataW, 32'h0);
    check("fault sticky",   {31'b0, MemFaultW}, 32'd1);
    load(5'd8, 32'h100);
    check("fault load zero", ReadDataW, 32'h0);
`else
    check("range truncated", ReadDataW, 32'h66);
    check("fault tied low",  {31'b0, MemFaultW}, 32'd0);
`endif
    bubble();
    #1 rst = 1'b0;
    #1;
    check("fault cleared", {31'b0, MemFaultW}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_cc.md
# memory_cc

Memory stage of the 32-bit RISC-V five-stage pipeline, directly downstream of the execute stage. It consumes the E/M-registered controls, address and store data, performs word stores to and loads from an internal data memory, and registers the M/W pipeline boundary. It also drives the combinational writeback result `ResultW`, which feeds the execute stage's forwarding mux.

## Interface
Parameters:
- `DEPTH`, default 64: data memory size in 32-bit words; must be a power of two.
- `AW`, default 6: word-index width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low: asserted while 0.
- `RegWriteM`  in  1  register-file write enable, carried to W.
- `ResultSrcM`  in  1  writeback select: 0 = ALU result, 1 = load data.
- `MemWriteM`  in  1  store enable.
- `RDM`  in  5  destination register.
- `ALUResultM`  in  32  byte address for loads/stores; ALU result for non-memory ops.
- `WriteDataM`  in  32  store data.
- `RegWriteW`  out  1  registered `RegWriteM`.
- `ResultSrcW`  out  1  registered `ResultSrcM`.
- `RDW`  out  5  registered `RDM`.
- `ALUResultW`  out  32  registered `ALUResultM`.
- `ReadDataW`  out  32  registered load data.
- `ResultW`  out  32  combinational: `ResultSrcW ? ReadDataW : ALUResultW`.
- `MemFaultW`  out  1  sticky access-fault flag; see Configuration.

## Operation
- Word index is `idx = ALUResultM[AW+1:2]`. Address bits `[1:0]` and bits above `AW+1` are ignored unless the bounds check is compiled in.
- Read path: `mem[idx]` is read asynchronously every cycle, regardless of `ResultSrcM`.
- Write path: on a rising edge with `MemWriteM = 1`, `mem[idx] <= WriteDataM`. Only full-word stores are supported.
- M/W register: on every rising edge, `RegWriteW`, `ResultSrcW`, `RDW`, `ALUResultW` and `ReadDataW` capture their M-side counterparts. `ReadDataW` captures the asynchronous read value.
- There is no stall or flush input. The execute stage inserts bubbles by driving `RegWriteM = 0` and `MemWriteM = 0`.
- `RDM = 0` is passed through unchanged. x0 is suppressed by the register file, not here.

## Timing
- Reset (`rst = 0`, asynchronous) forces all of the following to 0 immediately, independent of `clk`:
  - every W-side register;
  - `MemFaultW`;
  - every `mem` word.
  - As a result, `ResultW = 0`.
- Outputs stay 0 while `rst = 0`. The first capture happens on the first rising edge after `rst` returns to 1.
- Reset asserted mid-operation discards any store whose edge has not yet occurred.
- Load latency: address presented in cycle N gives data on `ReadDataW`/`ResultW` after edge N+1.
- Store visibility: a store at edge N is visible to a load whose address is presented in cycle N+1 or later.
- Store and read in the same cycle at the same index: `ReadDataW` captures the pre-store value (read-before-write).
- Back-to-back stores to the same index: the last one wins.
- `ResultW` changes only after a clock edge or reset; it has no path from M-side inputs.

## Configuration
- Macro: `MEMORY_CC_BOUNDS_CHECK_EN`.
- Defined:
  - An access is a fault if `ALUResultM[1:0] != 0` or `ALUResultM[31:AW+2] != 0`.
  - An access means `MemWriteM = 1`, or `ResultSrcM = 1` with `RegWriteM = 1`.
  - A faulting store does not write memory.
  - A faulting load captures `ReadDataW = 0`.
  - `MemFaultW` is set at the faulting edge and stays set until reset.
- Undefined: no checking is performed, the address is truncated to `idx`, and `MemFaultW` is tied to 0.

## Test plan
- Reset value: hold `rst = 0` and toggle `clk` with `MemWriteM = 1`, `WriteDataM = 32'hDEADBEEF` -> all outputs remain 0; a later load from address 0 returns 0.
- Store then load:
  - Store 32'h0000001E to address 8 at edge N.
  - Load with `ResultSrcM = 1`, `RegWriteM = 1`, `RDM = 5` at address 8 in cycle N+1.
  - Expect after edge N+2: `ReadDataW = 32'h1E`, `ResultW = 32'h1E`, `RDW = 5`, `RegWriteW = 1`.
- ALU passthrough: `ALUResultM = 32'd30`, `ResultSrcM = 0`, `RDM = 7` -> after one edge, `ALUResultW = 30`, `ResultW = 30`, `RDW = 7`, and no memory write occurs.
- Read-before-write:
  - `mem[2] = 32'h11`; in one cycle, store 32'h22 to address 8 while reading the same index.
  - Expect `ReadDataW = 32'h11`; the next load from address 8 returns 32'h22.
- Async reset mid-stream: after writes to addresses 0 and 4, assert `rst = 0` between edges -> outputs go to 0 without a clock edge; subsequent loads from 0 and 4 return 0.
- Bounds check (macro defined):
  - Store 32'h55 to address 32'h102 (misaligned) -> `MemFaultW = 1`, `mem[0]` unchanged.
  - Store 32'h66 to address 32'h100 (out of range, `DEPTH = 64`) -> no write; `MemFaultW` stays 1 until `rst = 0`.
  - Macro undefined: the store to 32'h100 writes `mem[0] = 32'h66` and `MemFaultW` stays 0.
